// File: rtl/signal_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | signal_ctrl_pkg                                                            |
// | Shared types and the tick-count to BCD conversion for the signal ctrl.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package signal_ctrl_pkg;

  localparam int c_elapsed_w = 10;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    AMBER  = 2'd1,
    ALLRED = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tenths;
  } bcd3_t;

  // Only ever evaluated on parameters, so the divisions fold away at elaboration.
  function automatic bcd3_t to_bcd3(input int ticks);
    bcd3_t r;
    r.tens   = 4'((ticks / 100) % 10);
    r.ones   = 4'((ticks / 10) % 10);
    r.tenths = 4'(ticks % 10);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | interval_timer                                                             |
// | Tick prescaler, BCD down-counter and elapsed-tick counter for one interval.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module interval_timer
  import signal_ctrl_pkg::*;
#(
  parameter int CLK_PER_TICK = 5_000_000,
  parameter int INIT_TICKS   = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  bcd3_t                  duration,
  output logic                   tick,
  output logic                   done,
  output logic [c_elapsed_w-1:0] elapsed,
  output bcd3_t                  countdown
);

  localparam int                c_pre_w    = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(CLK_PER_TICK - 1);
  localparam bcd3_t             c_init     = to_bcd3(INIT_TICKS);

  logic [c_pre_w-1:0]     r_prescale;
  logic [c_elapsed_w-1:0] r_elapsed;
  bcd3_t                  r_count;
  bcd3_t                  w_count_dec;

  assign tick      = (r_prescale == c_pre_last);
  assign done      = tick && (r_count.tens == 4'd0) && (r_count.ones == 4'd0) &&
                     (r_count.tenths <= 4'd1);
  assign elapsed   = r_elapsed;
  assign countdown = r_count;

  // Digit-wise borrow chain; 00.0 holds.
  always_comb begin
    w_count_dec = r_count;
    if (r_count.tenths != 4'd0) begin
      w_count_dec.tenths = r_count.tenths - 4'd1;
    end else if (r_count.ones != 4'd0) begin
      w_count_dec.ones   = r_count.ones - 4'd1;
      w_count_dec.tenths = 4'd9;
    end else if (r_count.tens != 4'd0) begin
      w_count_dec.tens   = r_count.tens - 4'd1;
      w_count_dec.ones   = 4'd9;
      w_count_dec.tenths = 4'd9;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
    end else if (load || tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + c_pre_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_init;
    end else if (load) begin
      r_count <= duration;
    end else if (tick) begin
      r_count <= w_count_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elapsed <= '0;
    end else if (load) begin
      r_elapsed <= '0;
    end else if (tick && (r_elapsed != '1)) begin
      r_elapsed <= r_elapsed + c_elapsed_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_phase_signal_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_phase_signal_ctrl                                                    |
// | N-approach signal sequencer with latched demand and round-robin service.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_phase_signal_ctrl
  import signal_ctrl_pkg::*;
#(
  parameter int NUM_PHASES      = 4,
  parameter int CLK_PER_TICK    = 5_000_000,
  parameter int GREEN_MIN_TICKS = 100,
  parameter int GREEN_MAX_TICKS = 300,
  parameter int AMBER_TICKS     = 30,
  parameter int ALLRED_TICKS    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         demand,
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         amber,
  output logic [NUM_PHASES-1:0]         green,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [1:0]                    state_o,
  output logic [3:0]                    cd_tens,
  output logic [3:0]                    cd_ones,
  output logic [3:0]                    cd_tenths,
  output logic [NUM_PHASES-1:0]         pending
);

  localparam int c_phase_w = $clog2(NUM_PHASES);

  localparam bcd3_t c_green_bcd  = to_bcd3(GREEN_MIN_TICKS);
  localparam bcd3_t c_amber_bcd  = to_bcd3(AMBER_TICKS);
  localparam bcd3_t c_allred_bcd = to_bcd3(ALLRED_TICKS);

  localparam logic [c_elapsed_w-1:0] c_min_last = c_elapsed_w'(GREEN_MIN_TICKS - 1);
  localparam logic [c_elapsed_w-1:0] c_max_last = c_elapsed_w'(GREEN_MAX_TICKS - 1);
  localparam logic [NUM_PHASES-1:0]  c_home     = NUM_PHASES'(1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [c_phase_w-1:0]   r_phase;
  logic [c_phase_w-1:0]   w_phase_next;
  logic [c_phase_w-1:0]   w_rr_phase;
  logic                   w_rr_found;
  logic [NUM_PHASES-1:0]  r_pending;
  logic [NUM_PHASES-1:0]  w_pending_next;
  logic [NUM_PHASES-1:0]  w_phase_mask;
  logic [NUM_PHASES-1:0]  w_green_mask;
  logic                   w_others;
  logic [NUM_PHASES-1:0]  r_red, r_amber, r_green;
  logic [NUM_PHASES-1:0]  w_red_next, w_amber_next, w_green_next;
  logic                   w_load;
  bcd3_t                  w_duration;
  logic                   w_tick;
  logic                   w_done;
  logic [c_elapsed_w-1:0] w_elapsed;
  bcd3_t                  w_countdown;
  logic                   w_min_ok;
  logic                   w_max_hit;

  function automatic logic [c_phase_w-1:0] wrap_add(input logic [c_phase_w-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_PHASES) s = s - NUM_PHASES;
    return c_phase_w'(s);
  endfunction

  interval_timer #(
    .CLK_PER_TICK (CLK_PER_TICK),
    .INIT_TICKS   (GREEN_MIN_TICKS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .duration  (w_duration),
    .tick      (w_tick),
    .done      (w_done),
    .elapsed   (w_elapsed),
    .countdown (w_countdown)
  );

  always_comb begin
    w_phase_mask          = '0;
    w_phase_mask[r_phase] = 1'b1;
  end

  assign w_green_mask = (r_state == GREEN) ? w_phase_mask : '0;
  assign w_others     = |(r_pending & ~w_phase_mask);
  // Compared against the pre-tick count so the exit lands on the tick that completes it.
  assign w_min_ok     = (w_elapsed >= c_min_last);
  assign w_max_hit    = (w_elapsed == c_max_last);

  // Search starts just past the active phase; the active phase itself is tried last.
  always_comb begin
    w_rr_phase = '0;
    w_rr_found = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      if (!w_rr_found && r_pending[wrap_add(r_phase, k)]) begin
        w_rr_found = 1'b1;
        w_rr_phase = wrap_add(r_phase, k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= GREEN;
      r_phase <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_load       = 1'b0;
    w_duration   = c_green_bcd;
    case (r_state)
      GREEN: begin
        if (w_tick && w_others && (w_min_ok || w_max_hit)) begin
          w_state_next = AMBER;
          w_load       = 1'b1;
          w_duration   = c_amber_bcd;
        end
      end
      AMBER: begin
        if (w_done) begin
          w_state_next = ALLRED;
          w_load       = 1'b1;
          w_duration   = c_allred_bcd;
        end
      end
      ALLRED: begin
        if (w_done) begin
          w_state_next = GREEN;
          w_phase_next = w_rr_phase;
          w_load       = 1'b1;
          w_duration   = c_green_bcd;
        end
      end
      default: begin
        w_state_next = GREEN;
        w_phase_next = '0;
        w_load       = 1'b1;
        w_duration   = c_green_bcd;
      end
    endcase
  end

  // Lamps are decoded from the next state so they are registered alongside it.
  always_comb begin
    w_green_next = '0;
    w_amber_next = '0;
    w_red_next   = '1;
    case (w_state_next)
      GREEN: begin
        w_green_next[w_phase_next] = 1'b1;
        w_red_next[w_phase_next]   = 1'b0;
      end
      AMBER: begin
        w_amber_next[w_phase_next] = 1'b1;
        w_red_next[w_phase_next]   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_pending_next = r_pending | (demand & ~w_green_mask);
    if (w_load && (w_state_next == GREEN)) begin
      w_pending_next[w_phase_next] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_green   <= c_home;
      r_amber   <= '0;
      r_red     <= ~c_home;
    end else begin
      r_pending <= w_pending_next;
      r_green   <= w_green_next;
      r_amber   <= w_amber_next;
      r_red     <= w_red_next;
    end
  end

  assign red          = r_red;
  assign amber        = r_amber;
  assign green        = r_green;
  assign pending      = r_pending;
  assign active_phase = r_phase;
  assign state_o      = r_state;
  assign cd_tens      = w_countdown.tens;
  assign cd_ones      = w_countdown.ones;
  assign cd_tenths    = w_countdown.tenths;

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_signal_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multi_phase_signal_ctrl                                                 |
// | Self-checking bench: vector table, directed corner cases, random vs model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multi_phase_signal_ctrl;

  localparam int NP   = 3;
  localparam int CPT  = 4;
  localparam int GMIN = 20;
  localparam int GMAX = 50;
  localparam int AMB  = 30;
  localparam int ALR  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] demand = 3'b000;
  logic [2:0] red, amber, green, pending;
  logic [1:0] active_phase, state_o;
  logic [3:0] cd_tens, cd_ones, cd_tenths;

  int checks = 0;
  int errors = 0;

  // Reference model: time in the current state counted in clk cycles.
  int         m_state, m_phase, m_cyc;
  logic [2:0] m_pend;

  typedef struct {
    int         hold;
    logic [2:0] dem;
    logic [1:0] st;
    logic [1:0] ph;
    logic [2:0] g;
    logic [2:0] a;
    logic [2:0] r;
    logic [2:0] pend;
    logic [11:0] cd;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  multi_phase_signal_ctrl #(
    .NUM_PHASES      (NP),
    .CLK_PER_TICK    (CPT),
    .GREEN_MIN_TICKS (GMIN),
    .GREEN_MAX_TICKS (GMAX),
    .AMBER_TICKS     (AMB),
    .ALLRED_TICKS    (ALR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .demand       (demand),
    .red          (red),
    .amber        (amber),
    .green        (green),
    .active_phase (active_phase),
    .state_o      (state_o),
    .cd_tens      (cd_tens),
    .cd_ones      (cd_ones),
    .cd_tenths    (cd_tenths),
    .pending      (pending)
  );

  task automatic model_reset();
    m_state = 0;
    m_phase = 0;
    m_cyc   = 0;
    m_pend  = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] d);
    int t, nxt, p;
    logic [2:0] mask, npend;
    t     = m_cyc + 1;
    mask  = 3'b001 << m_phase;
    npend = m_pend | (d & ((m_state == 0) ? ~mask : 3'b111));
    if (m_state == 0) begin
      if ((t % CPT) == 0 && ((t / CPT) >= GMIN || (t / CPT) == GMAX) && ((m_pend & ~mask) != 3'b000)) begin
        m_state = 1;
        t = 0;
      end
    end else if (m_state == 1) begin
      if (t == AMB * CPT) begin
        m_state = 2;
        t = 0;
      end
    end else begin
      if (t == ALR * CPT) begin
        nxt = -1;
        for (int k = 1; k <= NP; k++) begin
          p = (m_phase + k) % NP;
          if (nxt < 0 && m_pend[2'(p)]) nxt = p;
        end
        if (nxt < 0) nxt = 0;
        m_state = 0;
        m_phase = nxt;
        npend[2'(nxt)] = 1'b0;
        t = 0;
      end
    end
    m_cyc  = t;
    m_pend = npend;
  endtask

  task automatic check_vals(input string tag, input logic [1:0] st, input logic [1:0] ph,
                            input logic [2:0] g, input logic [2:0] a, input logic [2:0] r,
                            input logic [2:0] pend, input logic [11:0] cd);
    logic [11:0] acd;
    acd = {cd_tens, cd_ones, cd_tenths};
    checks++;
    if (state_o !== st || active_phase !== ph || green !== g || amber !== a ||
        red !== r || pending !== pend || acd !== cd) begin
      errors++;
      $display("FAIL %s: got st=%0d ph=%0d g=%b a=%b r=%b pend=%b cd=%h, want st=%0d ph=%0d g=%b a=%b r=%b pend=%b cd=%h",
               tag, state_o, active_phase, green, amber, red, pending, acd,
               st, ph, g, a, r, pend, cd);
    end
  endtask

  task automatic check_model(input string tag);
    int dur, rem;
    logic [2:0] eg, ea;
    dur = (m_state == 0) ? GMIN : (m_state == 1) ? AMB : ALR;
    rem = dur - m_cyc / CPT;
    if (rem < 0) rem = 0;
    eg = (m_state == 0) ? (3'b001 << m_phase) : 3'b000;
    ea = (m_state == 1) ? (3'b001 << m_phase) : 3'b000;
    check_vals(tag, 2'(m_state), 2'(m_phase), eg, ea, ~(eg | ea), m_pend,
               {4'(rem / 100), 4'((rem / 10) % 10), 4'(rem % 10)});
  endtask

  task automatic step(input logic [2:0] d, input string tag);
    demand = d;
    @(posedge clk);
    model_step(d);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    demand = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_vals("reset_state", 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b000, 12'h020);
  endtask

  initial begin
    int q[$];
    logic [1:0] prev_st;
    logic [2:0] d;

    // Single demand on phase 2 at cycle 10; checkpoints at absolute edge counts.
    tbl[0]  = '{10,  3'b000, 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b000, 12'h018};
    tbl[1]  = '{1,   3'b100, 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b100, 12'h018};
    tbl[2]  = '{68,  3'b000, 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b100, 12'h001};
    tbl[3]  = '{1,   3'b000, 2'd1, 2'd0, 3'b000, 3'b001, 3'b110, 3'b100, 12'h030};
    tbl[4]  = '{1,   3'b000, 2'd1, 2'd0, 3'b000, 3'b001, 3'b110, 3'b100, 12'h030};
    tbl[5]  = '{3,   3'b000, 2'd1, 2'd0, 3'b000, 3'b001, 3'b110, 3'b100, 12'h029};
    tbl[6]  = '{76,  3'b000, 2'd1, 2'd0, 3'b000, 3'b001, 3'b110, 3'b100, 12'h010};
    tbl[7]  = '{4,   3'b000, 2'd1, 2'd0, 3'b000, 3'b001, 3'b110, 3'b100, 12'h009};
    tbl[8]  = '{35,  3'b000, 2'd1, 2'd0, 3'b000, 3'b001, 3'b110, 3'b100, 12'h001};
    tbl[9]  = '{1,   3'b000, 2'd2, 2'd0, 3'b000, 3'b000, 3'b111, 3'b100, 12'h010};
    tbl[10] = '{39,  3'b000, 2'd2, 2'd0, 3'b000, 3'b000, 3'b111, 3'b100, 12'h001};
    tbl[11] = '{1,   3'b000, 2'd0, 2'd2, 3'b100, 3'b000, 3'b011, 3'b000, 12'h020};
    tbl[12] = '{80,  3'b000, 2'd0, 2'd2, 3'b100, 3'b000, 3'b011, 3'b000, 12'h000};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      for (int c = 0; c < tbl[i].hold; c++) step(tbl[i].dem, "single_model");
      check_vals($sformatf("single_vec%0d", i), tbl[i].st, tbl[i].ph, tbl[i].g, tbl[i].a,
                 tbl[i].r, tbl[i].pend, tbl[i].cd);
    end

    // Asynchronous reset in the middle of AMBER.
    do_reset();
    for (int c = 0; c < 5; c++) step(3'b000, "midamber_model");
    step(3'b010, "midamber_model");
    for (int c = 0; c < 134; c++) step(3'b000, "midamber_model");
    check_vals("pre_reset_amber", 2'd1, 2'd0, 3'b000, 3'b001, 3'b110, 3'b010, 12'h015);
    #2;
    rst = 1'b1;
    #1;
    check_vals("async_reset", 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b000, 12'h020);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // No demand after reset: full minimum, then rest at 00.0.
    for (int c = 1; c <= 400; c++) begin
      step(3'b000, "nodemand_model");
      if (c == 79)
        check_vals("nodemand_c79", 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b000, 12'h001);
      if (c == 80)
        check_vals("nodemand_c80", 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b000, 12'h000);
    end
    check_vals("nodemand_c400", 2'd0, 2'd0, 3'b001, 3'b000, 3'b110, 3'b000, 12'h000);

    // Round robin with demand 110 held; pending of the phase entering green must be clear.
    do_reset();
    prev_st = 2'd0;
    for (int c = 0; c < 1200 && q.size() < 3; c++) begin
      step(3'b110, "rr_model");
      if (state_o == 2'd0 && prev_st != 2'd0) begin
        q.push_back(int'(active_phase));
        checks++;
        if (pending[active_phase] !== 1'b0) begin
          errors++;
          $display("FAIL rr_clear_wins: pending=%b phase=%0d, want bit clear", pending, active_phase);
        end
      end
      prev_st = state_o;
    end
    checks++;
    if (q.size() < 3) begin
      errors++;
      $display("FAIL rr_timeout: got %0d green entries, want 3", q.size());
    end else if (q[0] != 1 || q[1] != 2 || q[2] != 1) begin
      errors++;
      $display("FAIL rr_order: got %0d,%0d,%0d want 1,2,1", q[0], q[1], q[2]);
    end

    // Random sparse demand against the model, with a reset partway through.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      for (int b = 0; b < 3; b++) d[b] = ($urandom_range(47) == 0);
      step(d, "random_model");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
